// File: rtl/qdr2_pkg.sv
// Shared widths, bring-up state encoding and idle pin constants for the QDR2 burst-of-2 controller.
package qdr2_pkg;

    localparam int QDR2_ADDR_W = 19;
    localparam int QDR2_DATA_W = 72;
    localparam int QDR2_BE_W   = 8;
    localparam int QDR2_TAG_W  = 4;

    typedef enum logic [1:0] {
        S_DOFF = 2'd0,
        S_LOCK = 2'd1,
        S_RUN  = 2'd2
    } qdr2_state_t;

    localparam logic [QDR2_BE_W-1:0] BWSB_IDLE = '1;

endpackage

// File: rtl/qdr2_b2_ctrl_if.sv
// User-side request/response bundle of the QDR2 controller: write and read request channels plus read return.
interface qdr2_b2_ctrl_if #(
    parameter int ADDR_W = qdr2_pkg::QDR2_ADDR_W,
    parameter int DATA_W = qdr2_pkg::QDR2_DATA_W,
    parameter int BE_W   = qdr2_pkg::QDR2_BE_W,
    parameter int TAG_W  = qdr2_pkg::QDR2_TAG_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]  rd_tag;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        output rd_valid, rd_addr, rd_tag,
        input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_addr, rd_tag,
        output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/qdr2_req_fifo.sv
// Request FIFO with an extra pointer bit for full/empty; head is presented combinationally on dout.
module qdr2_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             K,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout    = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // NOTE: only the state that must be known after reset (the pointers) uses <= with async reset;
    // every sequential assignment is non-blocking so all flops sample pre-edge values.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define which slots are valid.
    always_ff @(posedge K) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/qdr2_b2_ctrl.sv
// QDR2 burst-of-2 front end: DLL bring-up, one read and one write issue per K cycle, tagged read return.
module qdr2_b2_ctrl import qdr2_pkg::*; #(
    parameter int ADDR_W   = QDR2_ADDR_W,
    parameter int DATA_W   = QDR2_DATA_W,
    parameter int BE_W     = QDR2_BE_W,
    parameter int TAG_W    = QDR2_TAG_W,
    parameter int Q_DEPTH  = 4,
    parameter int RD_LAT   = 4,
    parameter int DOFF_CYC = 16,
    parameter int LOCK_CYC = 1024
) (
    input  logic              K,
    input  logic              RST,
    qdr2_b2_ctrl_if.slave     usr,
    output logic              init_done,
    output logic              RPSb,
    output logic              WPSb,
    output logic [ADDR_W-1:0] A_RD,
    output logic [ADDR_W-1:0] A_WR,
    output logic [DATA_W-1:0] D_W,
    output logic [BE_W-1:0]   BWSb,
    output logic              DOFF,
    input  logic [DATA_W-1:0] rd_q_in
);
    localparam int CNT_MAX = (DOFF_CYC > LOCK_CYC) ? DOFF_CYC : LOCK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WQ_W    = ADDR_W + DATA_W + BE_W;
    localparam int RQ_W    = ADDR_W + TAG_W;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } rd_slot_t;

    qdr2_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic              wr_ready, rd_ready;
    logic              wr_full, wr_empty, rd_full, rd_empty;
    logic [WQ_W-1:0]   wr_dout;
    logic [RQ_W-1:0]   rd_dout;
    logic [ADDR_W-1:0] wr_head_addr, rd_head_addr;
    logic [DATA_W-1:0] wr_head_data;
    logic [BE_W-1:0]   wr_head_be;
    logic [TAG_W-1:0]  rd_head_tag;
    logic [TAG_W-1:0]  rd_tag_q;

    rd_slot_t          rd_pipe [RD_LAT];
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    // ---------------- bring-up sequencer ----------------
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state <= S_DOFF;
            cnt   <= '0;
            DOFF  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            DOFF  <= (state_nxt != S_DOFF);
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            S_DOFF: if (cnt == CNT_W'(DOFF_CYC - 1)) begin
                state_nxt = S_LOCK;
                cnt_nxt   = '0;
            end
            S_LOCK: if (cnt == CNT_W'(LOCK_CYC - 1)) begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
            S_RUN:   cnt_nxt   = cnt;
            default: begin
                state_nxt = S_DOFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign init_done = (state == S_RUN);
    assign wr_ready  = init_done && !wr_full;
    assign rd_ready  = init_done && !rd_full;

    // ---------------- request queues ----------------
    qdr2_req_fifo #(.WIDTH(WQ_W), .DEPTH(Q_DEPTH)) u_wr_fifo (
        .K     (K),
        .RST   (RST),
        .push  (usr.wr_valid && wr_ready),
        .din   ({usr.wr_addr, usr.wr_data, usr.wr_be}),
        .pop   (!wr_empty),
        .dout  (wr_dout),
        .full  (wr_full),
        .empty (wr_empty)
    );

    qdr2_req_fifo #(.WIDTH(RQ_W), .DEPTH(Q_DEPTH)) u_rd_fifo (
        .K     (K),
        .RST   (RST),
        .push  (usr.rd_valid && rd_ready),
        .din   ({usr.rd_addr, usr.rd_tag}),
        .pop   (!rd_empty),
        .dout  (rd_dout),
        .full  (rd_full),
        .empty (rd_empty)
    );

    assign {wr_head_addr, wr_head_data, wr_head_be} = wr_dout;
    assign {rd_head_addr, rd_head_tag}              = rd_dout;

    // ---------------- pin issue ----------------
    // Address/data hold their last value when the port is idle to avoid needless pin toggling.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            WPSb     <= 1'b1;
            A_WR     <= '0;
            D_W      <= '0;
            BWSb     <= BWSB_IDLE;
            RPSb     <= 1'b1;
            A_RD     <= '0;
            rd_tag_q <= '0;
        end else begin
            WPSb <= wr_empty;
            if (!wr_empty) begin
                A_WR <= wr_head_addr;
                D_W  <= wr_head_data;
                BWSb <= ~wr_head_be;
            end
            RPSb <= rd_empty;
            if (!rd_empty) begin
                A_RD     <= rd_head_addr;
                rd_tag_q <= rd_head_tag;
            end
        end
    end

    // ---------------- read return alignment ----------------
    // Stage 0 samples the issued RPSb, so the tail lines up with the cycle rd_q_in is valid.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else begin
            rd_pipe[0] <= '{vld: ~RPSb, tag: rd_tag_q};
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            rsp_valid <= rd_pipe[RD_LAT-1].vld;
            if (rd_pipe[RD_LAT-1].vld) begin
                rsp_data <= rd_q_in;
                rsp_tag  <= rd_pipe[RD_LAT-1].tag;
            end
        end
    end

    assign usr.wr_ready  = wr_ready;
    assign usr.rd_ready  = rd_ready;
    assign usr.rsp_valid = rsp_valid;
    assign usr.rsp_data  = rsp_data;
    assign usr.rsp_tag   = rsp_tag;

endmodule

// File: tb/tb_qdr2_b2_ctrl.sv
// Bench for qdr2_b2_ctrl: directed vector table, multi-cycle corner sequences, and random traffic
// checked every cycle against a queue-based reference model.
module tb_qdr2_b2_ctrl;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 72;
    localparam int BE_W     = 8;
    localparam int TAG_W    = 4;
    localparam int Q_DEPTH  = 4;
    localparam int RD_LAT   = 4;
    localparam int DOFF_CYC = 16;
    localparam int LOCK_CYC = 1024;

    logic K   = 1'b0;
    logic RST = 1'b1;
    always #5 K = ~K;

    qdr2_b2_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .TAG_W(TAG_W)) usr ();

    logic              init_done, RPSb, WPSb, DOFF;
    logic [ADDR_W-1:0] A_RD, A_WR;
    logic [DATA_W-1:0] D_W, rd_q_in;
    logic [BE_W-1:0]   BWSb;

    qdr2_b2_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .TAG_W(TAG_W), .Q_DEPTH(Q_DEPTH),
        .RD_LAT(RD_LAT), .DOFF_CYC(DOFF_CYC), .LOCK_CYC(LOCK_CYC)
    ) dut (
        .K(K), .RST(RST), .usr(usr), .init_done(init_done), .RPSb(RPSb), .WPSb(WPSb),
        .A_RD(A_RD), .A_WR(A_WR), .D_W(D_W), .BWSb(BWSb), .DOFF(DOFF), .rd_q_in(rd_q_in)
    );

    // Standalone request FIFO, to reach the full/wrap corner that steady draining never exposes.
    logic       f_push = 1'b0, f_pop = 1'b0, f_full, f_empty;
    logic [7:0] f_din = '0, f_dout;
    qdr2_req_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .K(K), .RST(RST), .push(f_push), .din(f_din), .pop(f_pop),
        .dout(f_dout), .full(f_full), .empty(f_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wreq_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } rreq_t;
    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
    } pend_t;

    wreq_t wq[$];
    rreq_t rq[$];
    pend_t pq[$];
    int    ecnt;

    logic              e_wps, e_rps, e_doff, e_init, e_rsp_v;
    logic [ADDR_W-1:0] e_awr, e_ard;
    logic [DATA_W-1:0] e_dw, e_rsp_d;
    logic [BE_W-1:0]   e_bwsb;
    logic [TAG_W-1:0]  e_rsp_t;

    task automatic model_reset();
        wq.delete(); rq.delete(); pq.delete();
        ecnt = 0;
        e_wps = 1'b1; e_rps = 1'b1; e_awr = '0; e_ard = '0; e_dw = '0; e_bwsb = '1;
        e_doff = 1'b0; e_init = 1'b0; e_rsp_v = 1'b0; e_rsp_d = '0; e_rsp_t = '0;
    endtask

    task automatic model_step();
        bit    run, wpush, rpush;
        wreq_t w_in, w;
        rreq_t r_in, r;
        run   = (ecnt >= DOFF_CYC + LOCK_CYC);
        wpush = usr.wr_valid && run && (wq.size() < Q_DEPTH);
        rpush = usr.rd_valid && run && (rq.size() < Q_DEPTH);
        w_in  = '{addr: usr.wr_addr, data: usr.wr_data, be: usr.wr_be};
        r_in  = '{addr: usr.rd_addr, tag: usr.rd_tag};
        if (wq.size() > 0) begin
            w = wq.pop_front();
            e_wps = 1'b0; e_awr = w.addr; e_dw = w.data; e_bwsb = ~w.be;
        end else e_wps = 1'b1;
        if (rq.size() > 0) begin
            r = rq.pop_front();
            e_rps = 1'b0; e_ard = r.addr;
            pq.push_back('{due: ecnt + RD_LAT + 1, tag: r.tag});
        end else e_rps = 1'b1;
        if (pq.size() > 0 && pq[0].due == ecnt) begin
            e_rsp_v = 1'b1; e_rsp_d = rd_q_in; e_rsp_t = pq[0].tag;
            void'(pq.pop_front());
        end else e_rsp_v = 1'b0;
        if (wpush) wq.push_back(w_in);
        if (rpush) rq.push_back(r_in);
        ecnt++;
        e_doff = (ecnt >= DOFF_CYC);
        e_init = (ecnt >= DOFF_CYC + LOCK_CYC);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge K or posedge RST);
            if (RST) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge K);
            check("RPSb", RPSb, e_rps);
            check("WPSb", WPSb, e_wps);
            check("A_RD", A_RD, e_ard);
            check("A_WR", A_WR, e_awr);
            check("D_W", D_W, e_dw);
            check("BWSb", BWSb, e_bwsb);
            check("DOFF", DOFF, e_doff);
            check("init_done", init_done, e_init);
            check("wr_ready", usr.wr_ready, e_init && (wq.size() < Q_DEPTH));
            check("rd_ready", usr.rd_ready, e_init && (rq.size() < Q_DEPTH));
            check("rsp_valid", usr.rsp_valid, e_rsp_v);
            check("rsp_data", usr.rsp_data, e_rsp_d);
            check("rsp_tag", usr.rsp_tag, e_rsp_t);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit                wv;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [BE_W-1:0]   be;
        bit                rv;
        logic [ADDR_W-1:0] ra;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] q;
        logic              x_wps;
        logic              x_rps;
        logic [BE_W-1:0]   x_bwsb;
    } vec_t;

    vec_t vt[5];

    task automatic drive_idle();
        usr.wr_valid = 1'b0;
        usr.rd_valid = 1'b0;
    endtask

    task automatic wait_init(input string name, input int exp_cycles);
        int c = 0;
        while (!init_done && c < 2000) begin @(negedge K); c++; end
        check(name, c, exp_cycles);
    endtask

    initial begin
        logic [7:0] fexp[4];
        int got, cyc, c;

        vt[0] = '{wv:1, wa:19'h00010, wd:72'h1_2345_6789_ABCD_EF01, be:8'hFF, rv:0, ra:'0, tag:'0,
                  q:'0, x_wps:0, x_rps:1, x_bwsb:8'h00};
        vt[1] = '{wv:0, wa:'0, wd:'0, be:'0, rv:1, ra:19'h00010, tag:4'd5,
                  q:72'hA5_0F0F_1234_5678_9ABC, x_wps:1, x_rps:0, x_bwsb:8'h00};
        vt[2] = '{wv:1, wa:19'h00020, wd:72'hFF_0000_1111_2222_3333, be:8'h0F, rv:1, ra:19'h00020, tag:4'd0,
                  q:72'h12_3456_789A_BCDE_F012, x_wps:0, x_rps:0, x_bwsb:8'hF0};
        vt[3] = '{wv:1, wa:19'h7FFFF, wd:72'h80_0000_0000_0000_0001, be:8'h81, rv:0, ra:'0, tag:'0,
                  q:'0, x_wps:0, x_rps:1, x_bwsb:8'h7E};
        vt[4] = '{wv:0, wa:'0, wd:'0, be:'0, rv:1, ra:19'h7FFFF, tag:4'd15,
                  q:72'hDE_ADBE_EFCA_FEF0_0D00, x_wps:1, x_rps:0, x_bwsb:8'h00};
        fexp = '{8'd11, 8'd12, 8'd13, 8'd99};

        drive_idle();
        usr.wr_addr = '0; usr.wr_data = '0; usr.wr_be = '0; usr.rd_addr = '0; usr.rd_tag = '0;
        rd_q_in = '0;

        // Bring-up timing after reset release.
        repeat (3) @(negedge K);
        #2 RST = 1'b0;
        c = 0;
        while (!DOFF && c < 100) begin @(negedge K); c++; end
        check("doff_low_cycles", c, DOFF_CYC);
        check("rd_ready_during_lock", usr.rd_ready, 1'b0);
        wait_init("lock_cycles", LOCK_CYC);

        // Table of single requests, each with its pin image one cycle after accept and its response.
        for (int i = 0; i < 5; i++) begin
            @(negedge K);
            usr.wr_valid = vt[i].wv; usr.wr_addr = vt[i].wa; usr.wr_data = vt[i].wd; usr.wr_be = vt[i].be;
            usr.rd_valid = vt[i].rv; usr.rd_addr = vt[i].ra; usr.rd_tag = vt[i].tag;
            rd_q_in = vt[i].q;
            @(negedge K);
            drive_idle();
            @(negedge K);
            check("vec_WPSb", WPSb, vt[i].x_wps);
            check("vec_RPSb", RPSb, vt[i].x_rps);
            if (vt[i].wv) begin
                check("vec_A_WR", A_WR, vt[i].wa);
                check("vec_D_W", D_W, vt[i].wd);
                check("vec_BWSb", BWSb, vt[i].x_bwsb);
            end
            if (vt[i].rv) begin
                check("vec_A_RD", A_RD, vt[i].ra);
                c = 0;
                while (c < 10) begin
                    @(negedge K); c++;
                    if (usr.rsp_valid) break;
                end
                check("vec_rsp_latency", c, RD_LAT + 1);
                check("vec_rsp_tag", usr.rsp_tag, vt[i].tag);
                check("vec_rsp_data", usr.rsp_data, vt[i].q);
            end else repeat (2) @(negedge K);
        end

        // Four back-to-back writes drain one per cycle and never stall the user.
        for (int i = 0; i < 6; i++) begin
            @(negedge K);
            check("b2b_wr_ready", usr.wr_ready, 1'b1);
            if (i >= 2) begin
                check("b2b_WPSb", WPSb, 1'b0);
                check("b2b_A_WR", A_WR, ADDR_W'(100 + i - 2));
            end
            if (i < 4) begin
                usr.wr_valid = 1'b1; usr.wr_addr = ADDR_W'(100 + i);
                usr.wr_data = DATA_W'(i); usr.wr_be = 8'hFF;
            end else drive_idle();
        end
        @(negedge K);
        check("b2b_idle_WPSb", WPSb, 1'b1);

        // Read+write in the same cycle, then four reads returning in issue order.
        for (int i = 0; i < 5; i++) begin
            @(negedge K);
            if (i == 2) begin
                check("rw_RPSb", RPSb, 1'b0);
                check("rw_WPSb", WPSb, 1'b0);
                check("rw_BWSb", BWSb, 8'hF0);
            end
            rd_q_in = DATA_W'({$urandom(), $urandom(), $urandom()});
            usr.wr_valid = (i == 0); usr.wr_addr = 19'h00300; usr.wr_be = 8'h0F;
            usr.rd_valid = (i < 4); usr.rd_addr = 19'h00300; usr.rd_tag = TAG_W'(i);
        end
        drive_idle();
        got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            @(negedge K); cyc++;
            rd_q_in = DATA_W'({$urandom(), $urandom(), $urandom()});
            if (usr.rsp_valid) begin
                check("rsp_order", usr.rsp_tag, TAG_W'(got));
                got++;
            end
        end
        check("rsp_count", got, 4);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge K);
            usr.wr_valid = 1'($urandom_range(0, 1));
            usr.wr_addr  = ADDR_W'($urandom());
            usr.wr_data  = DATA_W'({$urandom(), $urandom(), $urandom()});
            usr.wr_be    = BE_W'($urandom());
            usr.rd_valid = 1'($urandom_range(0, 1));
            usr.rd_addr  = ADDR_W'($urandom());
            usr.rd_tag   = TAG_W'($urandom());
            rd_q_in      = DATA_W'({$urandom(), $urandom(), $urandom()});
        end
        @(negedge K);
        drive_idle();
        repeat (10) @(negedge K);

        // Reset with two reads in flight: nothing returns and bring-up restarts.
        usr.rd_valid = 1'b1; usr.rd_tag = 4'd7;
        @(negedge K);
        usr.rd_tag = 4'd8;
        @(negedge K);
        drive_idle();
        @(negedge K);
        #2 RST = 1'b1;
        #1;
        check("rst_RPSb", RPSb, 1'b1);
        check("rst_WPSb", WPSb, 1'b1);
        check("rst_BWSb", BWSb, 8'hFF);
        check("rst_DOFF", DOFF, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_rd_ready", usr.rd_ready, 1'b0);
        repeat (2) @(negedge K);
        #2 RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge K);
            check("post_rst_rsp_valid", usr.rsp_valid, 1'b0);
            check("post_rst_DOFF", DOFF, 1'b0);
        end
        wait_init("relock_cycles", DOFF_CYC + LOCK_CYC - 12);

        for (int i = 0; i < 60; i++) begin
            @(negedge K);
            usr.wr_valid = 1'($urandom_range(0, 1));
            usr.wr_addr  = ADDR_W'($urandom());
            usr.wr_be    = BE_W'($urandom());
            usr.rd_valid = 1'($urandom_range(0, 1));
            usr.rd_tag   = TAG_W'($urandom());
            rd_q_in      = DATA_W'({$urandom(), $urandom(), $urandom()});
        end
        @(negedge K);
        drive_idle();
        repeat (10) @(negedge K);

        // Request FIFO: fill, push+pop while full, then drain across the pointer wrap.
        check("fifo_empty_init", f_empty, 1'b1);
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1; f_din = 8'(10 + i);
            @(negedge K);
        end
        f_push = 1'b0;
        check("fifo_full", f_full, 1'b1);
        check("fifo_head", f_dout, 8'd10);
        f_push = 1'b1; f_pop = 1'b1; f_din = 8'd99;
        @(negedge K);
        f_push = 1'b0; f_pop = 1'b0;
        check("fifo_full_after_pushpop", f_full, 1'b1);
        f_pop = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("fifo_drain", f_dout, fexp[j]);
            @(negedge K);
        end
        f_pop = 1'b0;
        check("fifo_empty_end", f_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
